// File: rtl/picobello_pkg.sv
// Shared definitions for the HWPE control-port responder: sizes, register
// offsets, STATUS layout and the job-context record.
package picobello_pkg;

    localparam int unsigned NrCores     = 9;
    localparam int unsigned NumJobRegs  = 8;
    localparam int unsigned AddrWidth   = 32;
    localparam int unsigned JobIdWidth  = 8;
    localparam int unsigned CoreIdWidth = $clog2(NrCores);
    localparam int unsigned JobIdxWidth = $clog2(NumJobRegs);

    // Byte offsets; only address bits [7:2] are decoded.
    localparam logic [7:0] OFF_ACQUIRE    = 8'h00;
    localparam logic [7:0] OFF_TRIGGER    = 8'h04;
    localparam logic [7:0] OFF_STATUS     = 8'h08;
    localparam logic [7:0] OFF_SOFT_CLEAR = 8'h0C;
    localparam logic [7:0] OFF_PERF_CNT   = 8'h10;
    localparam logic [7:0] OFF_JOB_BASE   = 8'h40;
    localparam logic [7:0] OFF_JOB_END    = OFF_JOB_BASE + 8'(4 * NumJobRegs);

    localparam int unsigned STATUS_RUNNING_BIT = 0;
    localparam int unsigned STATUS_PENDING_BIT = 1;
    localparam int unsigned STATUS_OWNED_BIT   = 2;
    localparam int unsigned STATUS_JOB_ID_LSB  = 8;

    localparam logic [31:0] ACQUIRE_FAIL = 32'hFFFF_FFFF;

    typedef enum logic {
        CTX_IDLE,
        CTX_RUN
    } ctx_state_e;

    typedef struct packed {
        logic [NumJobRegs*32-1:0] regs;
        logic [CoreIdWidth-1:0]   owner;
        logic [JobIdWidth-1:0]    job_id;
    } hwpe_ctx_t;

    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_val[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/hwpe_ctrl_responder_if.sv
// TCDM-style 32-bit control channel between the bridge (master) and the
// HWPE control responder (slave).
interface hwpe_ctrl_responder_if;
    import picobello_pkg::*;

    logic                   q_valid;
    logic                   q_ready;
    logic [AddrWidth-1:0]   q_addr;
    logic                   q_write;
    logic [31:0]            q_data;
    logic [3:0]             q_strb;
    logic [CoreIdWidth-1:0] q_core;
    logic                   p_valid;
    logic [31:0]            p_data;

    modport master (
        output q_valid, q_addr, q_write, q_data, q_strb, q_core,
        input  q_ready, p_valid, p_data
    );

    modport slave (
        input  q_valid, q_addr, q_write, q_data, q_strb, q_core,
        output q_ready, p_valid, p_data
    );

endinterface

// File: rtl/hwpe_ctrl_ctx_regs.sv
// Job register storage: software-visible staging context with byte-masked
// writes, and the running context filled by a bulk copy at job start.
module hwpe_ctrl_ctx_regs
    import picobello_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   wr_en_i,
    input  logic [JobIdxWidth-1:0] wr_idx_i,
    input  logic [31:0]            wr_data_i,
    input  logic [3:0]             wr_strb_i,
    input  logic [JobIdxWidth-1:0] rd_idx_i,
    output logic [31:0]            rd_data_o,
    input  logic                   copy_i,
    input  logic [CoreIdWidth-1:0] copy_owner_i,
    input  logic [JobIdWidth-1:0]  copy_job_id_i,
    output hwpe_ctx_t              run_ctx_o
);

    logic [31:0]              stage_regs_reg [NumJobRegs];
    logic [31:0]              run_regs_reg   [NumJobRegs];
    logic [NumJobRegs*32-1:0] run_regs_flat;
    logic [CoreIdWidth-1:0]   run_owner_reg;
    logic [JobIdWidth-1:0]    run_job_id_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NumJobRegs; gi++) begin : g_job_reg
            // Clear beats both a staging write and a copy in the same cycle.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    stage_regs_reg[gi] <= '0;
                    run_regs_reg[gi]   <= '0;
                end else if (clear_i) begin
                    stage_regs_reg[gi] <= '0;
                    run_regs_reg[gi]   <= '0;
                end else begin
                    if (wr_en_i && (wr_idx_i == JobIdxWidth'(gi))) begin
                        stage_regs_reg[gi] <= strb_merge(stage_regs_reg[gi], wr_data_i, wr_strb_i);
                    end
                    if (copy_i) begin
                        run_regs_reg[gi] <= stage_regs_reg[gi];
                    end
                end
            end

            assign run_regs_flat[gi*32 +: 32] = run_regs_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_owner_reg  <= '0;
            run_job_id_reg <= '0;
        end else if (clear_i) begin
            run_owner_reg  <= '0;
            run_job_id_reg <= '0;
        end else if (copy_i) begin
            run_owner_reg  <= copy_owner_i;
            run_job_id_reg <= copy_job_id_i;
        end
    end

    assign rd_data_o = stage_regs_reg[rd_idx_i];
    assign run_ctx_o = '{regs: run_regs_flat, owner: run_owner_reg, job_id: run_job_id_reg};

endmodule

// File: rtl/hwpe_ctrl_responder.sv
// HWPE control-port responder: acquire/program/trigger job protocol over a
// double-buffered context. Define HWPE_CTRL_RESP_PERF_EN for the RUN-cycle counter at 0x10.
module hwpe_ctrl_responder
    import picobello_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_ni,
    hwpe_ctrl_responder_if.slave     ctrl,
    output logic [NumJobRegs*32-1:0] job_regs_o,
    output logic                     start_o,
    output logic                     clear_o,
    input  logic                     busy_i,
    input  logic                     done_i,
    output logic [NrCores-1:0]       evt_o
);

    ctx_state_e             state_reg;
    logic                   stage_owned_reg;
    logic                   stage_pending_reg;
    logic [CoreIdWidth-1:0] stage_owner_reg;
    logic [JobIdWidth-1:0]  stage_job_id_reg;
    logic [JobIdWidth-1:0]  job_id_reg;
    logic                   start_reg;
    logic                   clear_reg;
    logic [NrCores-1:0]     evt_reg;
    logic                   p_valid_reg;
    logic [31:0]            p_data_reg;

    logic [7:0]             addr_off;
    logic                   is_read;
    logic                   is_write;
    logic                   stage_free;
    logic                   owner_match;
    logic                   job_sel;
    logic [JobIdxWidth-1:0] job_idx;
    logic                   acquire_grant;
    logic                   trigger_ok;
    logic                   soft_clear;
    logic                   job_wr_ok;
    logic                   ctx_copy;
    logic [31:0]            stage_rd_data;
    logic [31:0]            status_word;
    logic [31:0]            rd_data;
    logic [NrCores-1:0]     evt_onehot;
    hwpe_ctx_t              run_ctx;
    logic                   unused_bits;

    assign addr_off    = {ctrl.q_addr[7:2], 2'b00};
    assign is_read     = ctrl.q_valid && !ctrl.q_write;
    assign is_write    = ctrl.q_valid && ctrl.q_write;
    assign stage_free  = !stage_owned_reg && !stage_pending_reg;
    assign owner_match = stage_owned_reg && (ctrl.q_core == stage_owner_reg);
    assign job_sel     = (addr_off >= OFF_JOB_BASE) && (addr_off < OFF_JOB_END);
    assign job_idx     = JobIdxWidth'(addr_off[7:2] - OFF_JOB_BASE[7:2]);

    assign acquire_grant = is_read && (addr_off == OFF_ACQUIRE) && stage_free;
    assign trigger_ok    = is_write && (addr_off == OFF_TRIGGER) && owner_match;
    assign soft_clear    = is_write && (addr_off == OFF_SOFT_CLEAR);
    assign job_wr_ok     = is_write && job_sel && owner_match;
    assign ctx_copy      = (state_reg == CTX_IDLE) && stage_pending_reg && !soft_clear;

    // An owner ID outside the core range shifts out and raises no event.
    assign evt_onehot = NrCores'(1) << run_ctx.owner;

    assign unused_bits = ^{ctrl.q_addr[AddrWidth-1:8], ctrl.q_addr[1:0], busy_i};

    hwpe_ctrl_ctx_regs u_ctx_regs (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (soft_clear),
        .wr_en_i       (job_wr_ok),
        .wr_idx_i      (job_idx),
        .wr_data_i     (ctrl.q_data),
        .wr_strb_i     (ctrl.q_strb),
        .rd_idx_i      (job_idx),
        .rd_data_o     (stage_rd_data),
        .copy_i        (ctx_copy),
        .copy_owner_i  (stage_owner_reg),
        .copy_job_id_i (stage_job_id_reg),
        .run_ctx_o     (run_ctx)
    );

`ifdef HWPE_CTRL_RESP_PERF_EN
    logic [31:0] perf_cnt_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_cnt_reg <= '0;
        end else if (soft_clear || (is_write && (addr_off == OFF_PERF_CNT))) begin
            perf_cnt_reg <= '0;
        end else if ((state_reg == CTX_RUN) && (perf_cnt_reg != 32'hFFFF_FFFF)) begin
            perf_cnt_reg <= perf_cnt_reg + 32'd1;
        end
    end
`endif

    always_comb begin
        status_word = '0;
        status_word[STATUS_RUNNING_BIT] = (state_reg == CTX_RUN);
        status_word[STATUS_PENDING_BIT] = stage_pending_reg;
        status_word[STATUS_OWNED_BIT]   = stage_owned_reg;
        status_word[STATUS_JOB_ID_LSB +: JobIdWidth] = run_ctx.job_id;
    end

    // Read data reflects state before this cycle's updates take effect.
    always_comb begin
        rd_data = '0;
        if (is_read) begin
            if (job_sel) begin
                rd_data = stage_rd_data;
            end else begin
                case (addr_off)
                    OFF_ACQUIRE: rd_data = stage_free ? 32'(job_id_reg) : ACQUIRE_FAIL;
                    OFF_STATUS:  rd_data = status_word;
`ifdef HWPE_CTRL_RESP_PERF_EN
                    OFF_PERF_CNT: rd_data = perf_cnt_reg;
`endif
                    default:     rd_data = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg         <= CTX_IDLE;
            stage_owned_reg   <= 1'b0;
            stage_pending_reg <= 1'b0;
            stage_owner_reg   <= '0;
            stage_job_id_reg  <= '0;
            job_id_reg        <= '0;
            start_reg         <= 1'b0;
            clear_reg         <= 1'b0;
            evt_reg           <= '0;
            p_valid_reg       <= 1'b0;
            p_data_reg        <= '0;
        end else begin
            start_reg   <= 1'b0;
            clear_reg   <= 1'b0;
            evt_reg     <= '0;
            p_valid_reg <= ctrl.q_valid;
            p_data_reg  <= rd_data;

            case (state_reg)
                CTX_IDLE: begin
                    if (stage_pending_reg) begin
                        start_reg         <= 1'b1;
                        stage_pending_reg <= 1'b0;
                        state_reg         <= CTX_RUN;
                    end
                end
                CTX_RUN: begin
                    if (done_i) begin
                        evt_reg   <= evt_onehot;
                        state_reg <= CTX_IDLE;
                    end
                end
                default: state_reg <= CTX_IDLE;
            endcase

            // Requests never collide with the start copy: a pending staging
            // context is neither owned nor acquirable.
            if (acquire_grant) begin
                stage_owned_reg  <= 1'b1;
                stage_owner_reg  <= ctrl.q_core;
                stage_job_id_reg <= job_id_reg;
                job_id_reg       <= job_id_reg + 1'b1;
            end
            if (trigger_ok) begin
                stage_owned_reg   <= 1'b0;
                stage_pending_reg <= 1'b1;
            end

            if (soft_clear) begin
                state_reg         <= CTX_IDLE;
                stage_owned_reg   <= 1'b0;
                stage_pending_reg <= 1'b0;
                stage_owner_reg   <= '0;
                stage_job_id_reg  <= '0;
                start_reg         <= 1'b0;
                evt_reg           <= '0;
                clear_reg         <= 1'b1;
            end
        end
    end

    assign ctrl.q_ready = 1'b1;
    assign ctrl.p_valid = p_valid_reg;
    assign ctrl.p_data  = p_data_reg;
    assign job_regs_o   = run_ctx.regs;
    assign start_o      = start_reg;
    assign clear_o      = clear_reg;
    assign evt_o        = evt_reg;

endmodule

// File: tb/tb_hwpe_ctrl_responder.sv
// Directed bench for hwpe_ctrl_responder; responses are checked against a
// queue of expected read data filled when each request is issued.
module tb_hwpe_ctrl_responder;
    import picobello_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NumJobRegs*32-1:0] job_regs;
    logic                     start;
    logic                     clear;
    logic                     busy = 1'b0;
    logic                     done = 1'b0;
    logic [NrCores-1:0]       evt;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_id = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    hwpe_ctrl_responder_if ctrl_if ();

    hwpe_ctrl_responder dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .ctrl       (ctrl_if),
        .job_regs_o (job_regs),
        .start_o    (start),
        .clear_o    (clear),
        .busy_i     (busy),
        .done_i     (done),
        .evt_o      (evt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_resp();
        string       tag;
        logic [31:0] exp;
        tag = tag_q.pop_front();
        exp = exp_q.pop_front();
        check({tag, "_pvalid"}, 32'(ctrl_if.p_valid), 32'd1);
        check(tag, ctrl_if.p_data, exp);
    endtask

    task automatic xfer(input logic wr, input logic [7:0] off, input logic [31:0] wdata,
                        input logic [3:0] strb, input int core, input logic [31:0] exp,
                        input string tag);
        ctrl_if.q_valid = 1'b1;
        ctrl_if.q_write = wr;
        ctrl_if.q_addr  = {24'h0, off};
        ctrl_if.q_data  = wdata;
        ctrl_if.q_strb  = strb;
        ctrl_if.q_core  = CoreIdWidth'(core);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        tick();
        ctrl_if.q_valid = 1'b0;
        ctrl_if.q_write = 1'b0;
        check_resp();
    endtask

    task automatic rd(input logic [7:0] off, input int core, input logic [31:0] exp, input string tag);
        xfer(1'b0, off, 32'h0, 4'h0, core, exp, tag);
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] data, input logic [3:0] strb,
                      input int core, input string tag);
        xfer(1'b1, off, data, strb, core, 32'h0, tag);
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    initial begin
        ctrl_if.q_valid = 1'b0;
        ctrl_if.q_write = 1'b0;
        ctrl_if.q_addr  = '0;
        ctrl_if.q_data  = '0;
        ctrl_if.q_strb  = '0;
        ctrl_if.q_core  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_start", 32'(start), 32'd0);
        check("rst_evt", 32'(evt), 32'd0);
        check("rst_pvalid", 32'(ctrl_if.p_valid), 32'd0);
        check("rst_job_regs", 32'(|job_regs), 32'd0);
        check("q_ready", 32'(ctrl_if.q_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic job from core 2
        rd(OFF_ACQUIRE, 2, 32'(exp_id), "basic_acq"); exp_id++;
        wr(OFF_JOB_BASE, 32'hDEAD_BEEF, 4'hF, 2, "basic_wr_job0");
        wr(OFF_TRIGGER, 32'h0, 4'hF, 2, "basic_trig");
        check("basic_start_early", 32'(start), 32'd0);
        tick();
        check("basic_start", 32'(start), 32'd1);
        check("basic_job0", job_regs[31:0], 32'hDEAD_BEEF);
        tick();
        check("basic_start_1cyc", 32'(start), 32'd0);
        check("idle_pvalid", 32'(ctrl_if.p_valid), 32'd0);
        rd(OFF_STATUS, 2, 32'h0000_0001, "basic_status");
        pulse_done();
        check("basic_evt", 32'(evt), 32'h004);
        tick();
        check("basic_evt_1cyc", 32'(evt), 32'h000);

        // Contention between core 0 and core 1
        rd(OFF_ACQUIRE, 0, 32'(exp_id), "cont_acq0"); exp_id++;
        rd(OFF_ACQUIRE, 1, ACQUIRE_FAIL, "cont_acq1");
        wr(OFF_JOB_BASE + 8'h04, 32'h0000_1234, 4'hF, 1, "cont_wr_core1");
        rd(OFF_JOB_BASE + 8'h04, 1, 32'h0, "cont_rd_job1");
        wr(OFF_JOB_BASE + 8'h04, 32'hAABB_CCDD, 4'b0101, 0, "cont_wr_strb");
        rd(OFF_JOB_BASE + 8'h04, 0, 32'h00BB_00DD, "cont_rd_strb");
        wr(OFF_TRIGGER, 32'h0, 4'hF, 1, "cont_trig_core1");
        rd(OFF_STATUS, 0, 32'h0000_0004, "cont_status");
        rd(8'h20, 0, 32'h0, "unmapped_rd");
        wr(OFF_TRIGGER, 32'h0, 4'hF, 0, "cont_trig_core0");
        tick();
        check("cont_start", 32'(start), 32'd1);
        pulse_done();
        check("cont_evt", 32'(evt), 32'h001);
        tick();

        // Double buffer: job A (core 3) running while job B (core 4) is staged
        rd(OFF_ACQUIRE, 3, 32'(exp_id), "db_acq_a"); exp_id++;
        wr(OFF_JOB_BASE + 8'h08, 32'h0000_1111, 4'hF, 3, "db_wr_a");
        wr(OFF_TRIGGER, 32'h0, 4'hF, 3, "db_trig_a");
        tick();
        check("db_start_a", 32'(start), 32'd1);
        check("db_job2_a", job_regs[95:64], 32'h0000_1111);
        rd(OFF_ACQUIRE, 4, 32'(exp_id), "db_acq_b"); exp_id++;
        wr(OFF_JOB_BASE, 32'h2222_2222, 4'hF, 4, "db_wr_b");
        wr(OFF_TRIGGER, 32'h0, 4'hF, 4, "db_trig_b");
        rd(OFF_STATUS, 4, 32'h0000_0203, "db_status");
        check("db_job0_still_a", job_regs[31:0], 32'hDEAD_BEEF);
        pulse_done();
        check("db_evt_a", 32'(evt), 32'h008);
        check("db_no_start_yet", 32'(start), 32'd0);
        rd(OFF_ACQUIRE, 5, ACQUIRE_FAIL, "acq_during_start");
        check("db_start_b", 32'(start), 32'd1);
        check("db_evt_1cyc", 32'(evt), 32'h000);
        check("db_job0_b", job_regs[31:0], 32'h2222_2222);
        rd(OFF_STATUS, 5, 32'h0000_0301, "db_status_b");

        // Soft clear while job B runs
        wr(OFF_SOFT_CLEAR, 32'h0, 4'hF, 5, "sc_wr");
        check("sc_clear", 32'(clear), 32'd1);
        check("sc_job_regs", 32'(|job_regs), 32'd0);
        rd(OFF_STATUS, 5, 32'h0, "sc_status");
        check("sc_clear_1cyc", 32'(clear), 32'd0);
        pulse_done();
        check("sc_no_evt", 32'(evt), 32'h000);
        rd(OFF_ACQUIRE, 6, 32'(exp_id), "sc_id_kept"); exp_id++;
        wr(OFF_TRIGGER, 32'h0, 4'hF, 6, "sc_trig");
        tick();
        check("sc_start", 32'(start), 32'd1);
        done = 1'b1;
        wr(OFF_SOFT_CLEAR, 32'h0, 4'hF, 6, "sc_with_done");
        done = 1'b0;
        check("sc_done_clear", 32'(clear), 32'd1);
        check("sc_done_no_evt", 32'(evt), 32'h000);
        tick();
        check("sc_done_no_evt_late", 32'(evt), 32'h000);

        // Trigger arriving in the same cycle as done
        rd(OFF_ACQUIRE, 1, 32'(exp_id), "td_acq1"); exp_id++;
        wr(OFF_TRIGGER, 32'h0, 4'hF, 1, "td_trig1");
        tick();
        check("td_start1", 32'(start), 32'd1);
        rd(OFF_ACQUIRE, 2, 32'(exp_id), "td_acq2"); exp_id++;
        done = 1'b1;
        wr(OFF_TRIGGER, 32'h0, 4'hF, 2, "td_trig2_done");
        done = 1'b0;
        check("td_evt1", 32'(evt), 32'h002);
        tick();
        check("td_start2", 32'(start), 32'd1);
        pulse_done();
        check("td_evt2", 32'(evt), 32'h004);
        tick();

        // Asynchronous reset with a running and a pending job
        rd(OFF_ACQUIRE, 0, 32'(exp_id), "ar_acq0"); exp_id++;
        wr(OFF_JOB_BASE + 8'h0C, 32'hCAFE_F00D, 4'hF, 0, "ar_wr0");
        wr(OFF_TRIGGER, 32'h0, 4'hF, 0, "ar_trig0");
        tick();
        rd(OFF_ACQUIRE, 1, 32'(exp_id), "ar_acq1"); exp_id++;
        wr(OFF_JOB_BASE, 32'h0000_0055, 4'hF, 1, "ar_wr1");
        wr(OFF_TRIGGER, 32'h0, 4'hF, 1, "ar_trig1");
        check("ar_job3_pre", job_regs[127:96], 32'hCAFE_F00D);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_pvalid", 32'(ctrl_if.p_valid), 32'd0);
        check("ar_job_regs", 32'(|job_regs), 32'd0);
        check("ar_start", 32'(start), 32'd0);
        check("ar_clear", 32'(clear), 32'd0);
        check("ar_evt", 32'(evt), 32'h000);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        rd(OFF_STATUS, 0, 32'h0, "ar_status");

        // Job-ID wrap; the first acquire also confirms the ID restarted at 0
        for (int i = 0; i < 256; i++) begin
            rd(OFF_ACQUIRE, i % 9, 32'(i), (i == 0) ? "ar_acq_after_reset" : "wrap_acq");
            wr(OFF_TRIGGER, 32'h0, 4'hF, i % 9, "wrap_trig");
            tick();
            pulse_done();
            tick();
        end
        rd(OFF_ACQUIRE, 0, 32'h0, "wrap_acq_zero");

`ifdef HWPE_CTRL_RESP_PERF_EN
        wr(OFF_PERF_CNT, 32'h0, 4'hF, 0, "perf_clr");
        wr(OFF_TRIGGER, 32'h0, 4'hF, 0, "perf_trig");
        tick();
        check("perf_start", 32'(start), 32'd1);
        repeat (9) tick();
        pulse_done();
        rd(OFF_PERF_CNT, 0, 32'd10, "perf_cnt");
`else
        rd(OFF_PERF_CNT, 0, 32'h0, "perf_absent");
`endif

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
